// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one adder iterated WIDTH times, start/done handshake,
// signed or unsigned operands chosen per operation, product split into HI/LO.
module mult_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   add_v;
   logic [PW-1:0]    raw_v;
   logic [PW-1:0]    res_v;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_CALC;
         S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      cnt_d  = cnt_q;
      p_d    = p_q;
      m_d    = m_q;
      q_d    = q_q;
      neg_d  = neg_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      busy_d = (state_d != S_IDLE);

      add_v = q_q[0] ? (p_q + {1'b0, m_q}) : p_q;
      raw_v = {p_q[WIDTH-1:0], q_q};
      res_v = neg_q ? (PW'(0) - raw_v) : raw_v;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               // Operate on magnitudes; the sign is re-applied once in FIX
               m_d   = (SIGNED && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
               q_d   = (SIGNED && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;
               neg_d = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
               p_d   = '0;
               cnt_d = CW'(WIDTH);
            end
         end
         S_CALC: begin
            p_d   = {1'b0, add_v[WIDTH:1]};
            q_d   = {add_v[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
         end
         S_FIX: begin
            hi_d   = res_v[PW-1:WIDTH];
            lo_d   = res_v[WIDTH-1:0];
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q  <= '0;
         p_q    <= '0;
         m_q    <= '0;
         q_q    <= '0;
         neg_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         p_q    <= p_d;
         m_q    <= m_d;
         q_q    <= q_d;
         neg_q  <= neg_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
